// File: rtl/sw_operand_entry.sv
// sw_operand_entry
//   Conditions two active-low push switches and turns presses into a
//   two-operand entry sequence (edit x, edit y, submit), then offers the
//   (x, y) pair over a valid/ready handshake. The LEDs show an active-low
//   preview of the field being edited.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   sw1       raw switch, active-low: increment current field
//   sw2       raw switch, active-low: short = advance/submit, long = clear field
//   x, y      submitted operands, constant while op_valid is high
//   op_valid  pair offered to the consumer
//   op_ready  consumer accepts the pair
//   boardLED  active-low preview: {field select, zero-extended value}
module sw_operand_entry #(
    parameter int W               = 5,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sw1,
    input  logic         sw2,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [5:0]   boardLED
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LCW = $clog2(LONG_CYCLES + 1);
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCW-1:0] LONG_MAX = LCW'(LONG_CYCLES);

    typedef enum logic [1:0] {EDIT_X, EDIT_Y, SEND} state_t;

    logic [1:0] sw_raw;
    logic [1:0] stab;     // debounced levels
    logic [1:0] fall_q;   // one-cycle pulse after a stable 1->0
    logic [1:0] rise_q;   // one-cycle pulse after a stable 0->1

    assign sw_raw = {sw2, sw1};

    // Per-switch synchronizer and debounce. The counter only runs while the
    // synchronized level disagrees with the stable level, so any bounce back
    // to the stable level restarts the count from zero.
    for (genvar i = 0; i < 2; i++) begin : g_sw
        logic [1:0]     sync_q;
        logic [DCW-1:0] cnt_q;
        logic           stab_q;
        logic           fall_pq;
        logic           rise_pq;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= 2'b11;
                cnt_q   <= '0;
                stab_q  <= 1'b1;
                fall_pq <= 1'b0;
                rise_pq <= 1'b0;
            end else begin
                sync_q  <= {sync_q[0], sw_raw[i]};
                fall_pq <= 1'b0;
                rise_pq <= 1'b0;
                if (sync_q[1] == stab_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    // This edge is the DEBOUNCE_CYCLES-th disagreeing cycle.
                    cnt_q   <= '0;
                    stab_q  <= sync_q[1];
                    fall_pq <= ~sync_q[1];
                    rise_pq <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign stab[i]   = stab_q;
        assign fall_q[i] = fall_pq;
        assign rise_q[i] = rise_pq;
    end

    // sw2 hold tracking. long_ev is gated by the stable low level so it can
    // never coincide with the release pulse of the same hold.
    logic [LCW-1:0] hold_q;
    logic           long_seen_q;
    logic           press_ev, long_ev, short_ev;

    assign press_ev = fall_q[0];
    assign long_ev  = !stab[1] && (hold_q == LONG_MAX) && !long_seen_q;
    assign short_ev = rise_q[1] && !long_seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            long_seen_q <= 1'b0;
        end else begin
            if (stab[1])
                hold_q <= '0;
            else if (hold_q != LONG_MAX)
                hold_q <= hold_q + 1'b1;

            if (rise_q[1])
                long_seen_q <= 1'b0;
            else if (long_ev)
                long_seen_q <= 1'b1;
        end
    end

    state_t         state_q;
    logic [W-1:0]   xw_q, yw_q;
    logic [W-1:0]   xw_d, yw_d;

    // Field updates happen before any transition in the same cycle, so a
    // press coinciding with a short release lands in the field being left.
    always_comb begin
        xw_d = xw_q;
        yw_d = yw_q;
        if (state_q == EDIT_X) begin
            if (long_ev)       xw_d = '0;
            else if (press_ev) xw_d = xw_q + 1'b1;
        end
        if (state_q == EDIT_Y) begin
            if (long_ev)       yw_d = '0;
            else if (press_ev) yw_d = yw_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EDIT_X;
            xw_q     <= '0;
            yw_q     <= '0;
            x        <= '0;
            y        <= '0;
            op_valid <= 1'b0;
        end else begin
            xw_q <= xw_d;
            yw_q <= yw_d;
            case (state_q)
                EDIT_X: if (short_ev) state_q <= EDIT_Y;
                EDIT_Y: begin
                    if (short_ev) begin
                        state_q  <= SEND;
                        x        <= xw_d;
                        y        <= yw_d;
                        op_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (op_ready) begin
                        state_q  <= EDIT_X;
                        op_valid <= 1'b0;
                    end
                end
                default: state_q <= EDIT_X;
            endcase
        end
    end

    // Preview lags the working registers by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boardLED <= 6'b111111;
        end else begin
            case (state_q)
                EDIT_X:  boardLED <= ~{1'b0, 5'(xw_q)};
                EDIT_Y:  boardLED <= ~{1'b1, 5'(yw_q)};
                default: boardLED <= 6'b000000;
            endcase
        end
    end

endmodule
